adc_interface_gen: RTL and testbench

//  Parametrised RX front end between ADC input pins and DDC bank: N_ADC channels of ADC_W bits.
//  Per channel: input register, closed-loop DC-offset removal with saturation, windowed overload count.

---
 rtl/adc_interface_gen.sv | 195 +++++++++++++++++++
 tb/tb_adc_interface_gen.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_interface_gen.sv
// ADC receive front end: input register, closed-loop DC removal with saturation, windowed overload
// counting and an atomically committed I/Q crossbar to the DDC bank. ADC_IF_PEAK_EN adds a peak output.
module adc_interface_gen #(
   parameter int         N_ADC      = 4,
   parameter int         ADC_W      = 12,
   parameter int         N_DDC      = 4,
   parameter logic [6:0] BASE_ADDR  = 7'd40,
   parameter int         LOOP_SHIFT = 16,
   parameter int         WIN_LOG2   = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   enable,
   input  logic [6:0]             serial_addr,
   input  logic [31:0]            serial_data,
   input  logic                   serial_strobe,
   input  logic                   frame_sync,
   input  logic [N_ADC*ADC_W-1:0] adc_in,
   output logic [N_DDC*16-1:0]    ddc_i,
   output logic [N_DDC*16-1:0]    ddc_q,
   output logic [N_ADC*16-1:0]    over_count,
`ifdef ADC_IF_PEAK_EN
   output logic [N_ADC*16-1:0]    peak,
`endif
   output logic                   mux_pending
);
   localparam int ACC_W = 16 + LOOP_SHIFT;
   // Overload codes are the two full-scale rails of the converter.
   localparam logic [ADC_W-1:0] CODE_POS = {1'b0, {(ADC_W-1){1'b1}}};
   localparam logic [ADC_W-1:0] CODE_NEG = {1'b1, {(ADC_W-1){1'b0}}};

   logic wr_ctrl, wr_shadow, wr_commit, wr_offset;
   logic shadow_ok, commit, wrap;
   logic [N_ADC-1:0]    dc_en_q;
   logic                real_q;
   logic                pending_q, pending_d;
   logic [WIN_LOG2-1:0] win_q;
   logic [15:0]         corr_pad [16];
   logic                unused_data;

   assign wr_ctrl   = serial_strobe && (serial_addr == BASE_ADDR);
   assign wr_shadow = serial_strobe && (serial_addr == BASE_ADDR + 7'd1);
   assign wr_commit = serial_strobe && (serial_addr == BASE_ADDR + 7'd2);
   assign wr_offset = serial_strobe && (serial_addr == BASE_ADDR + 7'd3);
   assign shadow_ok = wr_shadow && (serial_data[3:0] < 4'(N_DDC));
   assign commit    = wr_commit || (frame_sync && pending_q);
   assign wrap      = enable && (&win_q);
   assign unused_data = ^serial_data[15:12];

   // A shadow write colliding with a commit leaves the map pending.
   always_comb begin
      pending_d = pending_q;
      if (commit)    pending_d = 1'b0;
      if (shadow_ok) pending_d = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         dc_en_q   <= '0;
         real_q    <= 1'b0;
         pending_q <= 1'b0;
         win_q     <= '0;
      end else begin
         if (wr_ctrl) begin
            dc_en_q <= serial_data[N_ADC-1:0];
            real_q  <= serial_data[16];
         end
         pending_q <= pending_d;
         if (enable) win_q <= win_q + WIN_LOG2'(1);
      end
   end

   assign mux_pending = pending_q;

   for (genvar gi = 0; gi < N_ADC; gi++) begin : g_ch
      logic [ADC_W-1:0] adc_q;
      logic [ACC_W-1:0] acc_q, acc_d;
      logic [15:0]      x16, offset, corr_d, corr_q, cnt_q, cnt_d, over_q;
      logic [16:0]      diff;
      logic             is_over, off_hit;

      assign x16    = {{(16-ADC_W){adc_q[ADC_W-1]}}, adc_q} << (15 - ADC_W);
      assign offset = acc_q[ACC_W-1 -: 16];
      assign diff   = {x16[15], x16} - {offset[15], offset};

      always_comb begin
         corr_d = diff[15:0];
         if (diff[16] != diff[15]) corr_d = diff[16] ? 16'h8000 : 16'h7FFF;
      end

      assign off_hit = wr_offset && (serial_data[3:0] == 4'(gi));

      // A preset offset overrides the loop update in the same cycle.
      always_comb begin
         acc_d = acc_q;
         if (off_hit)
            acc_d = {serial_data[31:16], {LOOP_SHIFT{1'b0}}};
         else if (dc_en_q[gi])
            acc_d = acc_q + {{LOOP_SHIFT{corr_d[15]}}, corr_d};
      end

      assign is_over = (adc_q == CODE_POS) || (adc_q == CODE_NEG);

      always_comb begin
         cnt_d = cnt_q;
         if (wrap)
            cnt_d = {15'd0, is_over};
         else if (enable && is_over && (cnt_q != 16'hFFFF))
            cnt_d = cnt_q + 16'd1;
      end

      always_ff @(posedge clock) begin
         if (!reset) begin
            adc_q  <= '0;
            acc_q  <= '0;
            corr_q <= '0;
            cnt_q  <= '0;
            over_q <= '0;
         end else begin
            adc_q  <= adc_in[gi*ADC_W +: ADC_W];
            acc_q  <= acc_d;
            corr_q <= corr_d;
            cnt_q  <= cnt_d;
            if (wrap) over_q <= cnt_q;
         end
      end

      assign corr_pad[gi]                = corr_q;
      assign over_count[gi*16 +: 16]     = over_q;

`ifdef ADC_IF_PEAK_EN
      logic [15:0] mag, pk_q, pk_d, peak_q;

      always_comb begin
         mag = x16[15] ? 16'(-x16) : x16;
         if (x16 == 16'h8000) mag = 16'h7FFF;
         pk_d = pk_q;
         if (wrap)
            pk_d = mag;
         else if (enable && (mag > pk_q))
            pk_d = mag;
      end

      always_ff @(posedge clock) begin
         if (!reset) begin
            pk_q   <= '0;
            peak_q <= '0;
         end else begin
            pk_q <= pk_d;
            if (wrap) peak_q <= pk_q;
         end
      end

      assign peak[gi*16 +: 16] = peak_q;
`endif
   end

   // Unpopulated select codes read as zero.
   for (genvar gi = N_ADC; gi < 16; gi++) begin : g_pad
      assign corr_pad[gi] = '0;
   end

   for (genvar gi = 0; gi < N_DDC; gi++) begin : g_ddc
      logic [3:0]  isel_sh_q, qsel_sh_q, isel_q, qsel_q;
      logic [15:0] i_q, q_q;
      logic        sh_hit;

      assign sh_hit = wr_shadow && (serial_data[3:0] == 4'(gi));

      always_ff @(posedge clock) begin
         if (!reset) begin
            isel_sh_q <= '0;
            qsel_sh_q <= '0;
            isel_q    <= '0;
            qsel_q    <= '0;
            i_q       <= '0;
            q_q       <= '0;
         end else begin
            if (commit) begin
               isel_q <= isel_sh_q;
               qsel_q <= qsel_sh_q;
            end
            if (sh_hit) begin
               isel_sh_q <= serial_data[7:4];
               qsel_sh_q <= serial_data[11:8];
            end
            i_q <= corr_pad[isel_q];
            q_q <= real_q ? 16'd0 : corr_pad[qsel_q];
         end
      end

      assign ddc_i[gi*16 +: 16] = i_q;
      assign ddc_q[gi*16 +: 16] = q_q;
   end
endmodule

// File: tb/tb_adc_interface_gen.sv
// Self-checking bench for adc_interface_gen: table-driven crossbar vectors through a latency scoreboard,
// plus hand sequences for DC loop, saturation, atomic map commit and overload windows.
module tb_adc_interface_gen;
   localparam int         N_ADC = 4, ADC_W = 12, N_DDC = 4, LOOP_SHIFT = 4, WIN_LOG2 = 4;
   localparam logic [6:0] BASE  = 7'd40;

   logic                   clock = 1'b0, reset = 1'b0, enable = 1'b0;
   logic                   serial_strobe = 1'b0, frame_sync = 1'b0;
   logic [6:0]             serial_addr = '0;
   logic [31:0]            serial_data = '0;
   logic [N_ADC*ADC_W-1:0] adc_in = '0;
   logic [N_DDC*16-1:0]    ddc_i, ddc_q;
   logic [N_ADC*16-1:0]    over_count;
   logic                   mux_pending;
`ifdef ADC_IF_PEAK_EN
   logic [N_ADC*16-1:0]    peak;
`endif

   int checks = 0, failures = 0;

   adc_interface_gen #(
      .N_ADC(N_ADC), .ADC_W(ADC_W), .N_DDC(N_DDC), .BASE_ADDR(BASE),
      .LOOP_SHIFT(LOOP_SHIFT), .WIN_LOG2(WIN_LOG2)
   ) dut (
      .clock(clock), .reset(reset), .enable(enable),
      .serial_addr(serial_addr), .serial_data(serial_data), .serial_strobe(serial_strobe),
      .frame_sync(frame_sync), .adc_in(adc_in),
      .ddc_i(ddc_i), .ddc_q(ddc_q), .over_count(over_count),
`ifdef ADC_IF_PEAK_EN
      .peak(peak),
`endif
      .mux_pending(mux_pending)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   typedef struct packed {
      logic [47:0] adc;   // {ch3, ch2, ch1, ch0}
      logic [63:0] ei;    // {ddc3, ddc2, ddc1, ddc0}
      logic [63:0] eq;
   } vec_t;

   vec_t tbl [5];
   vec_t sb [$];
   vec_t e;

   // Crossbar outputs for per-channel corr {0x80, 0x100, 0x180, 0x200} under maps B and C.
   localparam logic [63:0] B_I = {16'h0200, 16'h0000, 16'h0100, 16'h0180};
   localparam logic [63:0] B_Q = {16'h0000, 16'h0180, 16'h0200, 16'h0080};
   localparam logic [63:0] C_I = {16'h0180, 16'h0100, 16'h0080, 16'h0200};
   localparam logic [63:0] C_Q = {16'h0200, 16'h0080, 16'h0180, 16'h0100};
   localparam logic [63:0] M_I = {16'h0180, 16'h0000, 16'h0100, 16'h0180};
   localparam logic [63:0] M_Q = {16'h0200, 16'h0180, 16'h0200, 16'h0080};

   logic signed [15:0] prev, cur;
   bit mono_ok, settled;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [1:0] off, input logic [31:0] data);
      serial_addr   = BASE + 7'(off);
      serial_data   = data;
      serial_strobe = 1'b1;
      @(negedge clock);
      serial_strobe = 1'b0;
   endtask

   task automatic map(input logic [3:0] k, input logic [3:0] isel, input logic [3:0] qsel);
      wr(2'd1, {20'd0, qsel, isel, k});
   endtask

   initial begin
      tbl[0] = '{adc: {12'h000, 12'h400, 12'h000, 12'h000},
                 ei:  {16'h0000, 16'h0000, 16'h0000, 16'h2000},
                 eq:  {16'h0000, 16'h2000, 16'h0000, 16'h0000}};
      tbl[1] = '{adc: {12'hFFF, 12'h800, 12'h7FF, 12'h123},
                 ei:  {16'hFFF8, 16'h0000, 16'h3FF8, 16'hC000},
                 eq:  {16'h0000, 16'hC000, 16'hFFF8, 16'h0918}};
      tbl[2] = '{adc: {12'h2AA, 12'h555, 12'h001, 12'hABC},
                 ei:  {16'h1550, 16'h0000, 16'h0008, 16'h2AA8},
                 eq:  {16'h0000, 16'h2AA8, 16'h1550, 16'hD5E0}};
      tbl[3] = '{adc: {12'h400, 12'h001, 12'h800, 12'h7FF},
                 ei:  {16'h2000, 16'h0000, 16'hC000, 16'h0008},
                 eq:  {16'h0000, 16'h0008, 16'h2000, 16'h3FF8}};
      tbl[4] = '{adc: {12'h0FF, 12'hF00, 12'h100, 12'hFFF},
                 ei:  {16'h07F8, 16'h0000, 16'h0800, 16'hF800},
                 eq:  {16'h0000, 16'hF800, 16'h07F8, 16'hFFF8}};

      // Reset dominates writes, frame_sync and enable.
      reset = 1'b0; enable = 1'b1; frame_sync = 1'b1;
      serial_addr = BASE + 7'd1; serial_data = 32'h0000_0231; serial_strobe = 1'b1;
      for (int n = 0; n < 3; n++) begin
         adc_in = {$urandom, $urandom};
         @(negedge clock);
      end
      check("rst_ddc_i", ddc_i, 64'd0);
      check("rst_ddc_q", ddc_q, 64'd0);
      check("rst_over", over_count, 64'd0);
      check("rst_pending", mux_pending, 1'b0);
      reset = 1'b1; enable = 1'b0; frame_sync = 1'b0; serial_strobe = 1'b0; adc_in = '0;
      repeat (3) @(negedge clock);
      check("rst_ddc_i_settled", ddc_i, 64'd0);

      // Latency through a serially committed map.
      map(4'd0, 4'd2, 4'd0);
      check("shadow_pending", mux_pending, 1'b1);
      wr(2'd2, 32'd0);
      check("commit_clears", mux_pending, 1'b0);
      adc_in[11:0]  = 12'h0F0;
      adc_in[35:24] = 12'h400;
      @(negedge clock);
      check("lat_edge1", ddc_i[15:0], 16'h0000);
      @(negedge clock);
      check("lat_edge2", ddc_i[15:0], 16'h0000);
      @(negedge clock);
      check("lat_edge3_i", ddc_i[15:0], 16'h2000);
      check("lat_edge3_q", ddc_q[15:0], 16'h0780);

      // Map B: DDC0 (2,0) DDC1 (1,3) DDC2 (9,2) DDC3 (3,15).
      map(4'd1, 4'd1, 4'd3);
      map(4'd2, 4'd9, 4'd2);
      map(4'd3, 4'd3, 4'd15);
      wr(2'd2, 32'd0);
      for (int n = 0; n < 8; n++) begin
         if (n >= 3) begin
            e = sb.pop_front();
            check("xbar_i", ddc_i, e.ei);
            check("xbar_q", ddc_q, e.eq);
            $display("vec %0d ddc_i=%h ddc_q=%h", n - 3, ddc_i, ddc_q);
         end
         if (n < 5) begin
            adc_in = tbl[n].adc;
            sb.push_back(tbl[n]);
         end
         @(negedge clock);
      end

      // DC loop on ch0, observed on DDC0 Q.
      adc_in = '0;
      adc_in[11:0] = 12'h100;
      repeat (4) @(negedge clock);
      check("dc_start", ddc_q[15:0], 16'h0800);
      wr(2'd0, 32'h0000_0001);
      prev = 16'sh0800; mono_ok = 1'b1; settled = 1'b0;
      for (int n = 0; n < 128 && !settled; n++) begin
         @(negedge clock);
         cur = ddc_q[15:0];
         if (cur > prev) mono_ok = 1'b0;
         if (cur < 16'sd16 && cur > -16'sd16) settled = 1'b1;
         prev = cur;
      end
      check("dc_monotonic", mono_ok, 1'b1);
      check("dc_settle", settled, 1'b1);
      wr(2'd0, 32'd0);
      wr(2'd3, 32'h0000_0000);

      // Offset preset and saturation on ch1, observed on DDC1 I.
      adc_in = '0;
      adc_in[23:12] = 12'h400;
      wr(2'd3, 32'h1000_0001);
      repeat (3) @(negedge clock);
      check("offset_sub", ddc_i[31:16], 16'h1000);
      adc_in[23:12] = 12'h7FF;
      wr(2'd3, 32'h8000_0001);
      repeat (3) @(negedge clock);
      check("sat_pos", ddc_i[31:16], 16'h7FFF);
      adc_in[23:12] = 12'h800;
      wr(2'd3, 32'h7FFF_0001);
      repeat (3) @(negedge clock);
      check("sat_neg", ddc_i[31:16], 16'h8000);
      wr(2'd3, 32'h0000_0001);

      // Atomic commit on frame_sync.
      adc_in = {12'h040, 12'h030, 12'h020, 12'h010};
      repeat (4) @(negedge clock);
      check("atom_base_i", ddc_i, B_I);
      check("atom_base_q", ddc_q, B_Q);
      map(4'd0, 4'd3, 4'd1);
      map(4'd1, 4'd0, 4'd2);
      map(4'd2, 4'd1, 4'd0);
      map(4'd3, 4'd2, 4'd3);
      repeat (3) @(negedge clock);
      check("atom_hold_i", ddc_i, B_I);
      check("atom_hold_pending", mux_pending, 1'b1);
      frame_sync = 1'b1;
      @(negedge clock);
      frame_sync = 1'b0;
      check("atom_commit_edge_i", ddc_i, B_I);
      check("atom_commit_clears", mux_pending, 1'b0);
      @(negedge clock);
      check("atom_switch_i", ddc_i, C_I);
      check("atom_switch_q", ddc_q, C_Q);

      // Shadow write colliding with frame_sync.
      map(4'd0, 4'd2, 4'd0);
      map(4'd1, 4'd1, 4'd3);
      map(4'd2, 4'd9, 4'd2);
      frame_sync = 1'b1;
      map(4'd3, 4'd3, 4'd15);
      frame_sync = 1'b0;
      check("collide_pending", mux_pending, 1'b1);
      @(negedge clock);
      check("collide_i", ddc_i, M_I);
      check("collide_q", ddc_q, M_Q);
      frame_sync = 1'b1;
      @(negedge clock);
      frame_sync = 1'b0;
      check("collide_final_pending", mux_pending, 1'b0);
      @(negedge clock);
      check("collide_final_i", ddc_i, B_I);
      check("collide_final_q", ddc_q, B_Q);
      map(4'd4, 4'd0, 4'd0);
      check("bad_ddc_ignored", mux_pending, 1'b0);

      // Real mode forces Q to zero.
      wr(2'd0, 32'h0001_0000);
      @(negedge clock);
      check("real_q_zero", ddc_q, 64'd0);
      check("real_i_kept", ddc_i, B_I);
      wr(2'd0, 32'd0);

      // Overload windows from a fresh reset (16-cycle windows).
      reset = 1'b0; enable = 1'b0; adc_in = '0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      check("ovl_reset", over_count, 64'd0);
      for (int d = 0; d < 58; d++) begin
         enable = !(d >= 35 && d <= 44);
         adc_in = '0;
         if ((d >= 14 && d <= 18) || (d >= 31 && d <= 42)) adc_in[47:36] = 12'h7FF;
         @(negedge clock);
         if (d == 30) check("ovl_first_window", over_count, 64'd0);
         if (d == 31 || d == 40 || d == 56) check("ovl_hold5", over_count, {16'd5, 48'd0});
         if (d == 57) check("ovl_frozen_window", over_count, {16'd3, 48'd0});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
